// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor: one full-subtractor cell plus a borrow FF, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic             brw;
   logic [CW-1:0]    cnt;

   logic a0, b0, d, brw_nxt, last;

   assign a0      = a_sr[0];
   assign b0      = b_sr[0];
   assign d       = a0 ^ b0 ^ brw;
   assign brw_nxt = (~a0 & b0) | (~(a0 ^ b0) & brw);
   assign last    = (cnt == CW'(WIDTH - 1));
   assign busy    = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
         done   <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  brw   <= bin;
                  cnt   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= {d, res_sr[WIDTH-1:1]};
               brw    <= brw_nxt;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  diff  <= {d, res_sr[WIDTH-1:1]};
                  bout  <= brw_nxt;
                  done  <= 1'b1;
                  state <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
                  // On the last bit a0/b0 are the captured sign bits and d is the result sign.
                  ovf   <= (a0 != b0) && (d != a0);
`endif
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): vector table plus corner-case sequences.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst, start, bin;
   logic [7:0] a, b;
   logic       busy, done, bout;
   logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int busy_cnt = 0;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) done_cnt = done_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issues one operation and returns the number of edges from acceptance to done (-1 on timeout).
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, output int lat);
      @(negedge clk);
      a = ia; b = ib; bin = ibin; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   vec_t vt[10];
   int   lat;
   logic [7:0] hold_diff;
   logic       hold_bout;

   initial begin
      vt[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
      vt[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
      vt[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      vt[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
      vt[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vt[5] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
      vt[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      vt[7] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      vt[8] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
      vt[9] = '{8'h55, 8'hAA, 1'b0, 8'hAB, 1'b1, 1'b1};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_diff", 32'(diff), 32'd0);
      chk("reset_bout", 32'(bout), 32'd0);

      // First op also checks busy length.
      busy_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         run_op(vt[i].a, vt[i].b, vt[i].bin, lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
         chk($sformatf("v%0d_diff", i), 32'(diff), 32'(vt[i].diff));
         chk($sformatf("v%0d_bout", i), 32'(bout), 32'(vt[i].bout));
`ifdef SERIAL_SUB_OVF_EN
         chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vt[i].ovf));
`endif
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
         if (i == 0) begin
            @(negedge clk);
            chk("busy_cycles", 32'(busy_cnt), 32'd9);
         end
      end

      // start while busy must be ignored
      done_cnt = 0;
      @(negedge clk);
      a = 8'h40; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("busy_start_diff", 32'(diff), 32'h3F);
      chk("busy_start_bout", 32'(bout), 32'd0);
      chk("busy_start_dones", 32'(done_cnt), 32'd1);

      // reset mid-RUN discards the operation
      done_cnt = 0;
      @(negedge clk);
      a = 8'h50; b = 8'h20; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_diff", 32'(diff), 32'd0);
      chk("midrst_bout", 32'(bout), 32'd0);
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("midrst_no_done", 32'(done_cnt), 32'd0);
      run_op(8'h50, 8'h20, 1'b0, lat);
      chk("after_rst_latency", 32'(lat), 32'd8);
      chk("after_rst_diff", 32'(diff), 32'h30);
      chk("after_rst_bout", 32'(bout), 32'd0);
      @(posedge clk);

      // outputs hold while idle with wiggling inputs
      hold_diff = diff;
      hold_bout = bout;
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      end
      @(negedge clk);
      chk("hold_diff", 32'(diff), 32'h30);
      chk("hold_bout", 32'(bout), 32'(hold_bout));
      chk("hold_no_done", 32'(done_cnt), 32'd0);
      chk("hold_idle", 32'(busy), 32'd0);
      chk("hold_diff_stable", 32'(diff), 32'(hold_diff));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
